// File: rtl/alu_md_controller.sv
`default_nettype none
// ============================================================================
// Module      : alu_md_controller
// Description : MIPS ALU control decoder (add/sub/slt/and/or/nor/sltu) with an
//               iterative multiply/divide unit that owns the HI/LO registers
//               and raises a stall while a HI/LO access meets a busy unit.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_md_controller #(
    parameter int WIDTH     = 32,
    parameter int ENABLE_MD = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       ALUop,
    input  logic [5:0]       func,
    input  logic             op_valid,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [2:0]       ALU_control,
    output logic [1:0]       hilo_sel,
    output logic             stall,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_mul  = 2'd1;
    localparam logic [1:0] c_st_div  = 2'd2;
    localparam logic [1:0] c_st_fix  = 2'd3;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH - 1);
    localparam logic             c_md_en    = (ENABLE_MD != 0);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_ph;      // product high half / partial remainder
    logic [WIDTH-1:0] r_pl;      // multiplier shifting out / quotient shifting in
    logic [WIDTH-1:0] r_mcand;   // multiplicand or divisor magnitude
    logic             r_is_div;
    logic             r_neg_a;
    logic             r_neg_b;
    logic             r_dz;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_is_rtype;
    logic             w_md_func;
    logic             w_hilo_op;
    logic             w_accept;
    logic             w_mthi;
    logic             w_mtlo;
    logic             w_signed_op;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_add_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;

    assign w_is_rtype = (ALUop == 2'b10);
    assign w_md_func  = c_md_en && w_is_rtype && (func inside {6'h18, 6'h19, 6'h1a, 6'h1b});
    assign w_hilo_op  = c_md_en && w_is_rtype &&
                        (func inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b});

    // Stall is suppressed during reset so the pipeline is never frozen by a dying operation
    assign md_busy  = (r_state != c_st_idle);
    assign md_done  = (r_state == c_st_fix);
    assign stall    = op_valid && w_hilo_op && md_busy && !rst;
    assign w_accept = (r_state == c_st_idle) && op_valid && !stall && w_md_func;
    assign w_mthi   = op_valid && !stall && c_md_en && w_is_rtype && (func == 6'h11);
    assign w_mtlo   = op_valid && !stall && c_md_en && w_is_rtype && (func == 6'h13);

    // Signed variants (mult, div) have func[0] clear; operands are reduced to magnitudes
    assign w_signed_op = !func[0];
    assign w_a_neg     = w_signed_op && src_a[WIDTH-1];
    assign w_b_neg     = w_signed_op && src_b[WIDTH-1];
    assign w_a_mag     = w_a_neg ? -src_a : src_a;
    assign w_b_mag     = w_b_neg ? -src_b : src_b;

    // One shift-add step and one restoring-division step share the same registers
    assign w_add_sum = {1'b0, r_ph} + (r_pl[0] ? {1'b0, r_mcand} : '0);
    assign w_shift   = {r_ph, r_pl[WIDTH-1]};
    assign w_trial   = w_shift - {1'b0, r_mcand};

    // Sign correction applied in the FIX cycle
    assign w_prod     = {r_ph, r_pl};
    assign w_prod_fix = (r_neg_a ^ r_neg_b) ? -w_prod : w_prod;
    assign w_quo      = (r_neg_a ^ r_neg_b) ? -r_pl : r_pl;
    assign w_rem      = r_neg_a ? -r_ph : r_ph;

    // ALU control decode; md/hilo funcs route the ALU through add when the unit exists
    always_comb begin
        ALU_control = 3'b111;
        case (ALUop)
            2'b00: ALU_control = 3'b000;
            2'b01: ALU_control = 3'b001;
            2'b11: ALU_control = 3'b010;
            default: begin
                case (func)
                    6'h20, 6'h21: ALU_control = 3'b000;
                    6'h22, 6'h23: ALU_control = 3'b001;
                    6'h2a:        ALU_control = 3'b010;
                    6'h24:        ALU_control = 3'b011;
                    6'h25:        ALU_control = 3'b100;
                    6'h27:        ALU_control = 3'b101;
                    6'h2b:        ALU_control = 3'b110;
                    6'h10, 6'h11, 6'h12, 6'h13,
                    6'h18, 6'h19, 6'h1a, 6'h1b:
                                  ALU_control = c_md_en ? 3'b000 : 3'b111;
                    default:      ALU_control = 3'b111;
                endcase
            end
        endcase
    end

    // Result mux select for mfhi/mflo, independent of op_valid
    always_comb begin
        hilo_sel = 2'b00;
        if (c_md_en && w_is_rtype && (func == 6'h10)) begin
            hilo_sel = 2'b01;
        end else if (c_md_en && w_is_rtype && (func == 6'h12)) begin
            hilo_sel = 2'b10;
        end
    end

    // Multiply/divide sequencer, iteration datapath and HI/LO registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_cnt    <= '0;
            r_ph     <= '0;
            r_pl     <= '0;
            r_mcand  <= '0;
            r_is_div <= 1'b0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_dz     <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_state  <= func[1] ? c_st_div : c_st_mul;
                        r_cnt    <= c_cnt_last;
                        r_ph     <= '0;
                        r_is_div <= func[1];
                        r_neg_a  <= w_a_neg;
                        r_neg_b  <= w_b_neg;
                        r_dz     <= (src_b == '0);
                        r_pl     <= func[1] ? w_a_mag : w_b_mag;
                        r_mcand  <= func[1] ? w_b_mag : w_a_mag;
                    end
                end
                c_st_mul: begin
                    r_ph <= w_add_sum[WIDTH:1];
                    r_pl <= {w_add_sum[0], r_pl[WIDTH-1:1]};
                    if (r_cnt == '0) r_state <= c_st_fix;
                    else             r_cnt   <= r_cnt - CNT_W'(1);
                end
                c_st_div: begin
                    if (!w_trial[WIDTH]) begin
                        r_ph <= w_trial[WIDTH-1:0];
                        r_pl <= {r_pl[WIDTH-2:0], 1'b1};
                    end else begin
                        r_ph <= w_shift[WIDTH-1:0];
                        r_pl <= {r_pl[WIDTH-2:0], 1'b0};
                    end
                    if (r_cnt == '0) r_state <= c_st_fix;
                    else             r_cnt   <= r_cnt - CNT_W'(1);
                end
                default: begin
                    r_state <= c_st_idle;
                    if (r_is_div) begin
                        // Remainder of a divide-by-zero is the dividend itself after sign fix
                        r_hi <= w_rem;
                        r_lo <= r_dz ? '1 : w_quo;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                end
            endcase
            // mthi/mtlo stall while busy, so they never collide with the FIX write
            if (w_mthi) r_hi <= src_a;
            if (w_mtlo) r_lo <= src_a;
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule
`default_nettype wire
